// File: rtl/chan_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : chan_scan_mux
// Purpose  : Registered N-channel, W-bit mux with manual select and automatic
//            round-robin dwell scanning. Optional macro: CHAN_MASK_EN
//            (adds chan_mask input, skips disabled channels).
// Revision : 1.0 - initial release
// ============================================================================
module chan_scan_mux #(
    parameter int   WIDTH    = 4,
    parameter int   CHANNELS = 4,
    parameter int   DWELL    = 8,
    localparam int  SW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      mode,
    input  logic [SW-1:0]             sel_in,
    input  logic                      hold,
`ifdef CHAN_MASK_EN
    input  logic [CHANNELS-1:0]       chan_mask,
`endif
    output logic [WIDTH-1:0]          m_out,
    output logic [SW-1:0]             m_sel,
    output logic [SW-1:0]             sel_out,
    output logic                      switched
);

    localparam int            CW         = $clog2(DWELL + 1);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(DWELL - 1);

    logic [SW-1:0]       r_sel;
    logic [CW-1:0]       r_cnt;
    logic                r_prev_mode;
    logic [WIDTH-1:0]    r_m_out;
    logic [SW-1:0]       r_m_sel;
    logic                r_switched;

    logic [CHANNELS-1:0] w_en;
    logic [WIDTH-1:0]    w_data;
    logic                w_sel_ok;
    logic [SW-1:0]       w_above;
    logic                w_above_found;
    logic [SW-1:0]       w_low;
    logic                w_low_found;
    logic [SW-1:0]       w_next;
    logic [SW-1:0]       w_sel_nxt;
    logic [CW-1:0]       w_cnt_nxt;

`ifdef CHAN_MASK_EN
    assign w_en = chan_mask;
`else
    assign w_en = {CHANNELS{1'b1}};
`endif

    // Compare-based selection keeps every index in range for non-power-of-two
    // channel counts; an out-of-range or disabled sel_in simply never matches.
    always_comb begin
        w_data        = '0;
        w_sel_ok      = 1'b0;
        w_above       = '0;
        w_above_found = 1'b0;
        w_low         = '0;
        w_low_found   = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (r_sel == SW'(c))
                w_data = data_in[c*WIDTH +: WIDTH];
            if (w_en[c] && (sel_in == SW'(c)))
                w_sel_ok = 1'b1;
            if (w_en[c]) begin
                if (!w_low_found) begin
                    w_low       = SW'(c);
                    w_low_found = 1'b1;
                end
                if (!w_above_found && (SW'(c) > r_sel)) begin
                    w_above       = SW'(c);
                    w_above_found = 1'b1;
                end
            end
        end
    end

    // Next enabled channel after r_sel with wrap; no enabled channel keeps r_sel.
    always_comb begin
        if (w_above_found)
            w_next = w_above;
        else if (w_low_found)
            w_next = w_low;
        else
            w_next = r_sel;
    end

    always_comb begin
        w_sel_nxt = r_sel;
        w_cnt_nxt = r_cnt;
        if (hold) begin
            w_sel_nxt = r_sel;
            w_cnt_nxt = r_cnt;
        end else if (!mode) begin
            w_cnt_nxt = '0;
            if (w_sel_ok)
                w_sel_nxt = sel_in;
        end else if (!r_prev_mode) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == c_CNT_LAST) begin
            w_cnt_nxt = '0;
            w_sel_nxt = w_next;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sel       <= '0;
            r_cnt       <= '0;
            r_prev_mode <= 1'b0;
            r_m_out     <= '0;
            r_m_sel     <= '0;
            r_switched  <= 1'b0;
        end else begin
            r_sel       <= w_sel_nxt;
            r_cnt       <= w_cnt_nxt;
            // Tracks mode even while held, so a mode edge under hold is consumed.
            r_prev_mode <= mode;
            r_m_out     <= w_data;
            r_m_sel     <= r_sel;
            r_switched  <= (w_sel_nxt != r_sel);
        end
    end

    assign m_out    = r_m_out;
    assign m_sel    = r_m_sel;
    assign sel_out  = r_sel;
    assign switched = r_switched;

endmodule
`default_nettype wire

// File: tb/tb_chan_scan_mux.sv
`default_nettype none
// Testbench for chan_scan_mux: default 4-channel instance for manual vectors,
// 3-channel DWELL=3 instance for scan, hold, range and mode-switch sequences.
module tb_chan_scan_mux;

    logic        clk = 1'b0;
    logic        resetn;

    logic [15:0] data0;
    logic        mode0, hold0;
    logic [1:0]  sel0;
    logic [3:0]  mout0;
    logic [1:0]  msel0, selo0;
    logic        sw0;
`ifdef CHAN_MASK_EN
    logic [3:0]  mask0;
    logic [2:0]  mask3;
`endif

    logic [11:0] data3;
    logic        mode3, hold3;
    logic [1:0]  sel3;
    logic [3:0]  mout3;
    logic [1:0]  msel3, selo3;
    logic        sw3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chan_scan_mux u_dut (
        .clk      (clk),
        .resetn   (resetn),
        .data_in  (data0),
        .mode     (mode0),
        .sel_in   (sel0),
        .hold     (hold0),
`ifdef CHAN_MASK_EN
        .chan_mask(mask0),
`endif
        .m_out    (mout0),
        .m_sel    (msel0),
        .sel_out  (selo0),
        .switched (sw0)
    );

    chan_scan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) u_dut3 (
        .clk      (clk),
        .resetn   (resetn),
        .data_in  (data3),
        .mode     (mode3),
        .sel_in   (sel3),
        .hold     (hold3),
`ifdef CHAN_MASK_EN
        .chan_mask(mask3),
`endif
        .m_out    (mout3),
        .m_sel    (msel3),
        .sel_out  (selo3),
        .switched (sw3)
    );

    typedef struct {
        logic [1:0]  sel_in;
        logic        hold;
        logic [15:0] data;
        logic [1:0]  e_sel;
        logic        e_sw;
        logic [3:0]  e_out;
        logic [1:0]  e_msel;
    } vec_t;

    vec_t vt [9];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string nm, input int e_sel, input int e_sw);
        chk({nm, " sel_out"}, int'(selo3), e_sel);
        chk({nm, " switched"}, int'(sw3), e_sw);
    endtask

    initial begin
        vt[0] = '{2'd2, 1'b0, 16'hD5A3, 2'd2, 1'b1, 4'h3, 2'd0};
        vt[1] = '{2'd2, 1'b0, 16'hD5A3, 2'd2, 1'b0, 4'h5, 2'd2};
        vt[2] = '{2'd3, 1'b0, 16'hD5A3, 2'd3, 1'b1, 4'h5, 2'd2};
        vt[3] = '{2'd3, 1'b0, 16'hD5A3, 2'd3, 1'b0, 4'hD, 2'd3};
        vt[4] = '{2'd1, 1'b0, 16'h1234, 2'd1, 1'b1, 4'h1, 2'd3};
        vt[5] = '{2'd1, 1'b1, 16'h1234, 2'd1, 1'b0, 4'h3, 2'd1};
        vt[6] = '{2'd0, 1'b1, 16'h1274, 2'd1, 1'b0, 4'h7, 2'd1};
        vt[7] = '{2'd0, 1'b0, 16'h1274, 2'd0, 1'b1, 4'h7, 2'd1};
        vt[8] = '{2'd0, 1'b0, 16'hFFFF, 2'd0, 1'b0, 4'hF, 2'd0};

`ifdef CHAN_MASK_EN
        mask0 = 4'hF;
        mask3 = 3'h7;
`endif
        // Reset with random inputs
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data0 = 16'($urandom);
            mode0 = 1'($urandom);
            hold0 = 1'($urandom);
            sel0  = 2'($urandom);
            data3 = 12'($urandom);
            mode3 = 1'($urandom);
            hold3 = 1'($urandom);
            sel3  = 2'($urandom);
            tick();
        end
        chk("rst m_out",    int'(mout0), 0);
        chk("rst m_sel",    int'(msel0), 0);
        chk("rst sel_out",  int'(selo0), 0);
        chk("rst switched", int'(sw0),   0);
        chk("rst3 sel_out", int'(selo3), 0);
        chk("rst3 m_out",   int'(mout3), 0);

        resetn = 1'b1;
        mode0 = 1'b0; hold0 = 1'b0; sel0 = 2'd0; data0 = 16'hD5A3;
        mode3 = 1'b0; hold3 = 1'b0; sel3 = 2'd0; data3 = 12'hCBA;

        // Manual-mode vector table
        for (int i = 0; i < 9; i++) begin
            sel0  = vt[i].sel_in;
            hold0 = vt[i].hold;
            data0 = vt[i].data;
            tick();
            chk($sformatf("vec%0d sel_out", i),  int'(selo0), int'(vt[i].e_sel));
            chk($sformatf("vec%0d switched", i), int'(sw0),   int'(vt[i].e_sw));
            chk($sformatf("vec%0d m_out", i),    int'(mout0), int'(vt[i].e_out));
            chk($sformatf("vec%0d m_sel", i),    int'(msel0), int'(vt[i].e_msel));
        end

        // Auto scan with wrap: 3 channels, dwell 3, channel c carries 10+c
        mode3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            int prev_ch;
            tick();
            prev_ch = (i == 0) ? 0 : ((i - 1) / 3) % 3;
            chk3($sformatf("scan%0d", i), (i / 3) % 3, (i > 0 && i % 3 == 0) ? 1 : 0);
            chk($sformatf("scan%0d m_sel", i), int'(msel3), prev_ch);
            chk($sformatf("scan%0d m_out", i), int'(mout3), 10 + prev_ch);
        end

        // Advance to sel_out=1 with cnt=1, then hold for 5 cycles
        repeat (4) tick();
        chk3("prehold", 1, 0);
        hold3 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data3 = {4'hC, 4'(k + 3), 4'hA};
            tick();
            chk3($sformatf("hold%0d", k), 1, 0);
            chk($sformatf("hold%0d m_out", k), int'(mout3), k + 3);
        end
        hold3 = 1'b0;
        data3 = 12'hCBA;
        tick(); chk3("release1", 1, 0);
        tick(); chk3("release2", 2, 1);

        // Out-of-range manual select is ignored
        mode3 = 1'b0; sel3 = 2'd3;
        tick(); chk3("oor1", 2, 0);
        tick(); chk3("oor2", 2, 0);

        // Manual to auto: first advance DWELL edges later, wraps to 0
        mode3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk3($sformatf("m2a%0d", i), 2, 0);
        end
        tick(); chk3("m2a3", 0, 1);
        chk("m2a3 m_sel", int'(msel3), 2);
        chk("m2a3 m_out", int'(mout3), 12);

        // Auto to manual mid-dwell loads sel_in on the same edge
        tick(); chk3("a2m pre", 0, 0);
        mode3 = 1'b0; sel3 = 2'd1;
        tick(); chk3("a2m", 1, 1);

        // Mode change under hold is consumed; release resumes without clear
        hold3 = 1'b1; mode3 = 1'b1;
        tick(); chk3("hm hold", 1, 0);
        hold3 = 1'b0;
        tick(); chk3("hm r1", 1, 0);
        tick(); chk3("hm r2", 1, 0);
        tick(); chk3("hm r3", 2, 1);

        // Reset mid-dwell
        tick();
        resetn = 1'b0;
        tick();
        chk3("midrst", 0, 0);
        chk("midrst m_out", int'(mout3), 0);
        chk("midrst m_sel", int'(msel3), 0);
        resetn = 1'b1;

`ifdef CHAN_MASK_EN
        begin
            int nsw;
            int seq [4];
            int held;
            nsw = 0;
            mask0 = 4'b1010;
            mode0 = 1'b1; hold0 = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (sw0 && nsw < 4) begin
                    seq[nsw] = int'(selo0);
                    nsw++;
                end
            end
            chk("mask switches", nsw, 4);
            chk("mask seq0", seq[0], 1);
            chk("mask seq1", seq[1], 3);
            chk("mask seq2", seq[2], 1);
            chk("mask seq3", seq[3], 3);
            mask0 = 4'b0000;
            held = int'(selo0);
            for (int i = 0; i < 20; i++) begin
                tick();
                chk($sformatf("nomask%0d sel_out", i), int'(selo0), held);
                chk($sformatf("nomask%0d switched", i), int'(sw0), 0);
            end
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
